isr_sequencer: RTL and testbench

Multi-cycle controller that sequences interrupt entry and `eret` return around the SPR file and the interrupt controller. On `jisr` it stalls the pipeline and performs the ordered context save through the single SPR write port: ESR, ECA, EPC, EDPC, EDATA, then SR and mode. It then redirects the PC to the ISR start address. On `eret` it restores SR and PC from ESR and EPC and returns to user mode. It sits between the interrupt controller (cause/`jisr`/`rpt`) and the SPR file, and owns the SPR write port whenever `busy` is high.

---
 rtl/isr_pkg.sv | 31 +++
 rtl/isr_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_isr_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/isr_pkg.sv
// isr_pkg: shared constants for the interrupt entry/return sequencer.
//   SPR_*   : SPR file addresses (3-bit)
//   MODE_*  : values written to the MODE SPR
//   ST_*    : 4-bit FSM state encoding
package isr_pkg;

   localparam logic [2:0] SPR_SR    = 3'd0;
   localparam logic [2:0] SPR_ESR   = 3'd1;
   localparam logic [2:0] SPR_ECA   = 3'd2;
   localparam logic [2:0] SPR_EPC   = 3'd3;
   localparam logic [2:0] SPR_EDPC  = 3'd4;
   localparam logic [2:0] SPR_EDATA = 3'd5;
   localparam logic [2:0] SPR_RSVD  = 3'd6;
   localparam logic [2:0] SPR_MODE  = 3'd7;

   localparam logic [31:0] MODE_SYS = 32'h0000_0000;
   localparam logic [31:0] MODE_USR = 32'h0000_0001;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_S_ESR   = 4'd1;
   localparam logic [3:0] ST_S_ECA   = 4'd2;
   localparam logic [3:0] ST_S_EPC   = 4'd3;
   localparam logic [3:0] ST_S_EDPC  = 4'd4;
   localparam logic [3:0] ST_S_EDATA = 4'd5;
   localparam logic [3:0] ST_S_SR    = 4'd6;
   localparam logic [3:0] ST_S_JMP   = 4'd7;
   localparam logic [3:0] ST_R_SR    = 4'd8;
   localparam logic [3:0] ST_R_PC    = 4'd9;
   localparam logic [3:0] ST_R_MODE  = 4'd10;

endpackage

// File: rtl/isr_sequencer.sv
// isr_sequencer: sequences interrupt entry (context save into the SPR file,
// then PC redirect to SISR) and eret return (restore SR/PC, back to user mode).
// Owns the SPR write port while busy is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   jisr, eret        entry / return requests, sampled only in IDLE
//   mca, rpt          masked cause and repeat flag, latched with jisr
//   pc, next_pc, ea   context latched with jisr
//   spr_rdata         combinational SPR read data for spr_raddr
//   spr_raddr         SPR read select
//   spr_we/waddr/wdata SPR write port, decoded from the current state
//   pc_load/pc_target one-cycle PC redirect
//   stall, busy       pipeline freeze / sequence in progress
//   irq_count         ISR entries taken; counts only when ISR_COUNT_EN is
//                     defined, otherwise tied to zero
//
// State table:
//   state      | meaning
//   IDLE       | waiting; reads SR so it can be latched with jisr
//   S_ESR      | write ESR <- latched SR
//   S_ECA      | write ECA <- {9'b0, mca}
//   S_EPC      | write EPC <- rpt ? pc : next_pc
//   S_EDPC     | write EDPC <- next_pc
//   S_EDATA    | write EDATA <- ea
//   S_SR       | write SR <- 0 (mask all)
//   S_JMP      | write MODE <- system, redirect PC to SISR
//   R_SR       | write SR <- ESR
//   R_PC       | redirect PC to EPC
//   R_MODE     | write MODE <- user
module isr_sequencer
   import isr_pkg::*;
#(
   parameter logic [31:0] SISR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jisr,
   input  logic        eret,
   input  logic [22:0] mca,
   input  logic        rpt,
   input  logic [31:0] pc,
   input  logic [31:0] next_pc,
   input  logic [31:0] ea,
   input  logic [31:0] spr_rdata,
   output logic [2:0]  spr_raddr,
   output logic        spr_we,
   output logic [2:0]  spr_waddr,
   output logic [31:0] spr_wdata,
   output logic        pc_load,
   output logic [31:0] pc_target,
   output logic        stall,
   output logic        busy,
   output logic [31:0] irq_count
);

   logic [3:0]  state_q,   state_d;
   logic [31:0] sr_lat_q,  sr_lat_d;
   logic [22:0] mca_q,     mca_d;
   logic        rpt_q,     rpt_d;
   logic [31:0] pc_lat_q,  pc_lat_d;
   logic [31:0] npc_lat_q, npc_lat_d;
   logic [31:0] ea_lat_q,  ea_lat_d;

   logic idle;
   logic take_entry;

   assign idle       = (state_q == ST_IDLE);
   assign take_entry = idle & jisr;

   always_comb begin
      state_d   = state_q;
      sr_lat_d  = sr_lat_q;
      mca_d     = mca_q;
      rpt_d     = rpt_q;
      pc_lat_d  = pc_lat_q;
      npc_lat_d = npc_lat_q;
      ea_lat_d  = ea_lat_q;
      spr_raddr = SPR_SR;
      spr_we    = 1'b0;
      spr_waddr = SPR_SR;
      spr_wdata = 32'h0;
      pc_load   = 1'b0;
      pc_target = 32'h0;

      case (state_q)
         ST_IDLE: begin
            // jisr has priority; a coincident eret is dropped
            if (jisr) begin
               sr_lat_d  = spr_rdata;
               mca_d     = mca;
               rpt_d     = rpt;
               pc_lat_d  = pc;
               npc_lat_d = next_pc;
               ea_lat_d  = ea;
               state_d   = ST_S_ESR;
            end else if (eret) begin
               state_d   = ST_R_SR;
            end
         end
         ST_S_ESR: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_ESR;
            spr_wdata = sr_lat_q;
            state_d   = ST_S_ECA;
         end
         ST_S_ECA: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_ECA;
            spr_wdata = {9'b0, mca_q};
            state_d   = ST_S_EPC;
         end
         ST_S_EPC: begin
            // repeat-type interrupts re-execute the faulting instruction
            spr_we    = 1'b1;
            spr_waddr = SPR_EPC;
            spr_wdata = rpt_q ? pc_lat_q : npc_lat_q;
            state_d   = ST_S_EDPC;
         end
         ST_S_EDPC: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_EDPC;
            spr_wdata = npc_lat_q;
            state_d   = ST_S_EDATA;
         end
         ST_S_EDATA: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_EDATA;
            spr_wdata = ea_lat_q;
            state_d   = ST_S_SR;
         end
         ST_S_SR: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_SR;
            spr_wdata = 32'h0;
            state_d   = ST_S_JMP;
         end
         ST_S_JMP: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_MODE;
            spr_wdata = MODE_SYS;
            pc_load   = 1'b1;
            pc_target = SISR;
            state_d   = ST_IDLE;
         end
         ST_R_SR: begin
            spr_raddr = SPR_ESR;
            spr_we    = 1'b1;
            spr_waddr = SPR_SR;
            spr_wdata = spr_rdata;
            state_d   = ST_R_PC;
         end
         ST_R_PC: begin
            spr_raddr = SPR_EPC;
            pc_load   = 1'b1;
            pc_target = spr_rdata;
            state_d   = ST_R_MODE;
         end
         ST_R_MODE: begin
            spr_we    = 1'b1;
            spr_waddr = SPR_MODE;
            spr_wdata = MODE_USR;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sr_lat_q  <= 32'h0;
         mca_q     <= 23'h0;
         rpt_q     <= 1'b0;
         pc_lat_q  <= 32'h0;
         npc_lat_q <= 32'h0;
         ea_lat_q  <= 32'h0;
      end else begin
         state_q   <= state_d;
         sr_lat_q  <= sr_lat_d;
         mca_q     <= mca_d;
         rpt_q     <= rpt_d;
         pc_lat_q  <= pc_lat_d;
         npc_lat_q <= npc_lat_d;
         ea_lat_q  <= ea_lat_d;
      end
   end

   assign busy = ~idle;
   // Trigger cycle is frozen too; held low while reset is asserted.
   assign stall = busy | (idle & ~rst & (jisr | eret));

`ifdef ISR_COUNT_EN
   logic [31:0] irq_count_q, irq_count_d;

   always_comb begin
      irq_count_d = irq_count_q;
      if (take_entry) begin
         irq_count_d = irq_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_count_q <= 32'h0;
      end else begin
         irq_count_q <= irq_count_d;
      end
   end

   assign irq_count = irq_count_q;
`else
   assign irq_count = 32'h0;
`endif

endmodule

// File: tb/tb_isr_sequencer.sv
// tb_isr_sequencer: directed bench for isr_sequencer with a small SPR file
// model. Inputs driven on the falling edge, outputs sampled 1 ns later.
module tb_isr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        jisr, eret, rpt;
   logic [22:0] mca;
   logic [31:0] pc, next_pc, ea;
   logic [31:0] spr_rdata;
   logic [2:0]  spr_raddr, spr_waddr;
   logic        spr_we, pc_load, stall, busy;
   logic [31:0] spr_wdata, pc_target, irq_count;

   logic [31:0] spr [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   isr_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .jisr      (jisr),
      .eret      (eret),
      .mca       (mca),
      .rpt       (rpt),
      .pc        (pc),
      .next_pc   (next_pc),
      .ea        (ea),
      .spr_rdata (spr_rdata),
      .spr_raddr (spr_raddr),
      .spr_we    (spr_we),
      .spr_waddr (spr_waddr),
      .spr_wdata (spr_wdata),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .stall     (stall),
      .busy      (busy),
      .irq_count (irq_count)
   );

   assign spr_rdata = spr[spr_raddr];

   always @(posedge clk) begin
      if (spr_we) spr[spr_waddr] <= spr_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Full entry sequence with per-cycle checks. dual: eret together with
   // jisr at T0. pulse: jisr re-pulsed at T3 while busy.
   task automatic run_entry(input logic rpt_v, input logic [22:0] mca_v,
                            input logic [31:0] pc_v, input logic [31:0] npc_v,
                            input logic [31:0] ea_v, input bit dual, input bit pulse);
      logic [2:0]  exp_a [8];
      logic [31:0] exp_d [8];
      exp_a[1] = 3'd1; exp_d[1] = spr[0];
      exp_a[2] = 3'd2; exp_d[2] = {9'b0, mca_v};
      exp_a[3] = 3'd3; exp_d[3] = rpt_v ? pc_v : npc_v;
      exp_a[4] = 3'd4; exp_d[4] = npc_v;
      exp_a[5] = 3'd5; exp_d[5] = ea_v;
      exp_a[6] = 3'd0; exp_d[6] = 32'h0;
      exp_a[7] = 3'd7; exp_d[7] = 32'h0;
      @(negedge clk);
      jisr = 1'b1; eret = dual; rpt = rpt_v; mca = mca_v;
      pc = pc_v; next_pc = npc_v; ea = ea_v;
      #1;
      check("t0_stall", 32'(stall), 32'd1);
      check("t0_busy", 32'(busy), 32'd0);
      check("t0_we", 32'(spr_we), 32'd0);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 1) begin
            // scramble inputs to prove the latched copies are used
            jisr = 1'b0; eret = 1'b0; rpt = ~rpt_v; mca = 23'h7F_FFFF;
            pc = 32'hDEAD_BEEF; next_pc = 32'hCAFE_F00D; ea = 32'h1234_5678;
         end
         if (pulse && i == 3) jisr = 1'b1;
         if (pulse && i == 4) jisr = 1'b0;
         #1;
         check($sformatf("t%0d_we", i), 32'(spr_we), 32'd1);
         check($sformatf("t%0d_waddr", i), 32'(spr_waddr), 32'(exp_a[i]));
         check($sformatf("t%0d_wdata", i), spr_wdata, exp_d[i]);
         check($sformatf("t%0d_stall", i), 32'(stall), 32'd1);
         check($sformatf("t%0d_pcload", i), 32'(pc_load), (i == 7) ? 32'd1 : 32'd0);
         if (i == 7) check("t7_target", pc_target, 32'h0);
      end
      @(negedge clk); #1;
      check("t8_busy", 32'(busy), 32'd0);
      check("t8_stall", 32'(stall), 32'd0);
      check("t8_we", 32'(spr_we), 32'd0);
   endtask

   initial begin
      rst = 1'b1; jisr = 1'b0; eret = 1'b0; rpt = 1'b0; mca = 23'h0;
      pc = 32'h0; next_pc = 32'h0; ea = 32'h0;
      for (int i = 0; i < 8; i++) spr[i] = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_we", 32'(spr_we), 32'd0);
      check("rst_waddr", 32'(spr_waddr), 32'd0);
      check("rst_wdata", spr_wdata, 32'd0);
      check("rst_pcload", 32'(pc_load), 32'd0);
      check("rst_target", pc_target, 32'd0);
      check("rst_count", irq_count, 32'd0);
      rst = 1'b0;

      // Basic entry
      spr[0] = 32'h0000_00FF;
      run_entry(1'b0, 23'h000004, 32'h100, 32'h104, 32'h2000, 1'b0, 1'b0);
      check("e_esr", spr[1], 32'hFF);
      check("e_eca", spr[2], 32'h4);
      check("e_epc", spr[3], 32'h104);
      check("e_edpc", spr[4], 32'h104);
      check("e_edata", spr[5], 32'h2000);
      check("e_sr", spr[0], 32'h0);
      check("e_mode", spr[7], 32'h0);

      // Return: ESR=FF, EPC=104 from the entry above
      @(negedge clk);
      eret = 1'b1; #1;
      check("r0_stall", 32'(stall), 32'd1);
      check("r0_we", 32'(spr_we), 32'd0);
      @(negedge clk);
      eret = 1'b0; #1;
      check("r1_raddr", 32'(spr_raddr), 32'd1);
      check("r1_we", 32'(spr_we), 32'd1);
      check("r1_waddr", 32'(spr_waddr), 32'd0);
      check("r1_wdata", spr_wdata, 32'hFF);
      check("r1_pcload", 32'(pc_load), 32'd0);
      @(negedge clk); #1;
      check("r2_raddr", 32'(spr_raddr), 32'd3);
      check("r2_we", 32'(spr_we), 32'd0);
      check("r2_pcload", 32'(pc_load), 32'd1);
      check("r2_target", pc_target, 32'h104);
      @(negedge clk); #1;
      check("r3_we", 32'(spr_we), 32'd1);
      check("r3_waddr", 32'(spr_waddr), 32'd7);
      check("r3_wdata", spr_wdata, 32'h1);
      check("r3_stall", 32'(stall), 32'd1);
      @(negedge clk); #1;
      check("r4_busy", 32'(busy), 32'd0);
      check("r4_stall", 32'(stall), 32'd0);
      check("r_sr", spr[0], 32'hFF);
      check("r_mode", spr[7], 32'h1);

      // Repeat interrupt, simultaneous eret, jisr re-pulse while busy
      run_entry(1'b1, 23'h000004, 32'h100, 32'h104, 32'h2000, 1'b1, 1'b1);
      check("rpt_epc", spr[3], 32'h100);
      check("rpt_esr", spr[1], 32'hFF);
      @(negedge clk); #1;
      check("rpt_no_restart", 32'(busy), 32'd0);

      // Reset at T4 of entry aborts with no further writes
      spr[0] = 32'h55; spr[5] = 32'hA5A5_A5A5;
      @(negedge clk);
      jisr = 1'b1; mca = 23'h1; pc = 32'h300; next_pc = 32'h304; ea = 32'h40;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         jisr = 1'b0;
      end
      #1;
      check("a4_waddr", 32'(spr_waddr), 32'd4);
      rst = 1'b1;
      @(negedge clk); #1;
      check("a_busy", 32'(busy), 32'd0);
      check("a_we", 32'(spr_we), 32'd0);
      check("a_pcload", 32'(pc_load), 32'd0);
      check("a_stall", 32'(stall), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("a_idle", 32'(busy), 32'd0);
      check("a_edata", spr[5], 32'hA5A5_A5A5);
      check("a_sr", spr[0], 32'h55);

      // Three entries after reset
      for (int k = 0; k < 3; k++)
         run_entry(1'b0, 23'(k + 1), 32'h500, 32'h504, 32'h600, 1'b0, 1'b0);
`ifdef ISR_COUNT_EN
      check("count3", irq_count, 32'd3);
      @(negedge clk);
      force dut.irq_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.irq_count_q;
      #1;
      check("count_pre", irq_count, 32'hFFFF_FFFF);
      run_entry(1'b0, 23'h2, 32'h700, 32'h704, 32'h800, 1'b0, 1'b0);
      check("count_wrap", irq_count, 32'h0);
`else
      check("count_tied", irq_count, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
